// File: rtl/note_pkg.sv
// note_pkg
//   Shared definitions for the four-lane rhythm-game note engine.
//   Holds the lane/position constants, the per-level spawn interval
//   constants, the spawn-pattern ROM and the interval lookup.
//   No ports; imported by note_spawner and note_lane.

package note_pkg;

  localparam int NUM_LANES = 4;
  localparam int POS_W     = 4;
  localparam int SPAWN_POS = 15;

  localparam int INT_L1 = 8;
  localparam int INT_L2 = 4;
  localparam int INT_L3 = 2;

  // Lane mask for a spawn event; bit i selects lane i.
  // Level 1 only walks through four single-lane patterns, so it uses step[1:0].
  function automatic logic [NUM_LANES-1:0] pattern(input logic [1:0] level,
                                                   input logic [2:0] step);
    logic [NUM_LANES-1:0] mask;
    mask = '0;
    case (level)
      2'd1: begin
        case (step[1:0])
          2'd0: mask = 4'b0001;
          2'd1: mask = 4'b0010;
          2'd2: mask = 4'b0100;
          default: mask = 4'b1000;
        endcase
      end
      2'd2: begin
        case (step)
          3'd0: mask = 4'b0001;
          3'd1: mask = 4'b0100;
          3'd2: mask = 4'b0010;
          3'd3: mask = 4'b1000;
          3'd4: mask = 4'b0101;
          3'd5: mask = 4'b1010;
          3'd6: mask = 4'b0011;
          default: mask = 4'b1100;
        endcase
      end
      2'd3: begin
        case (step)
          3'd0: mask = 4'b0011;
          3'd1: mask = 4'b0110;
          3'd2: mask = 4'b1100;
          3'd3: mask = 4'b1001;
          3'd4: mask = 4'b0101;
          3'd5: mask = 4'b1010;
          3'd6: mask = 4'b1111;
          default: mask = 4'b0000;
        endcase
      end
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Number of animation ticks between spawn events; 0 for the idle level.
  function automatic logic [3:0] interval_sel(input logic [1:0] level,
                                              input int int_l1,
                                              input int int_l2,
                                              input int int_l3);
    logic [3:0] ivl;
    case (level)
      2'd1:    ivl = 4'(int_l1);
      2'd2:    ivl = 4'(int_l2);
      2'd3:    ivl = 4'(int_l3);
      default: ivl = 4'd0;
    endcase
    return ivl;
  endfunction

endpackage

// File: rtl/note_lane.sv
// note_lane
//   One lane of the note engine: holds the lane's note position and
//   applies spawn / hit / fall priority.
//   Ports:
//     clk, rst    - clock, async active-high reset
//     spawn_req   - spawn event selects this lane this clk
//     hit         - player hit / clear request for this lane
//     tick        - one-clk animation tick
//     pos         - current position, 0 = empty
//     spawned     - one-clk pulse coinciding with a SPAWN_POS load

module note_lane
  import note_pkg::*;
#(
  parameter int LANE_POS_W     = POS_W,
  parameter int LANE_SPAWN_POS = SPAWN_POS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spawn_req,
  input  logic                  hit,
  input  logic                  tick,
  output logic [LANE_POS_W-1:0] pos,
  output logic                  spawned
);

  logic lane_empty;

  assign lane_empty = (pos == '0);

  // A spawn only takes an occupied lane if the player clears it in the same
  // clk; otherwise the request is dropped and the old note keeps falling.
  // Falling from 1 to 0 is a silent miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos     <= '0;
      spawned <= 1'b0;
    end else begin
      spawned <= 1'b0;
      if (spawn_req && (lane_empty || hit)) begin
        pos     <= LANE_POS_W'(LANE_SPAWN_POS);
        spawned <= 1'b1;
      end else if (hit) begin
        pos <= '0;
      end else if (tick && !lane_empty) begin
        pos <= pos - 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_spawner.sv
// note_spawner
//   Four-lane rhythm-game note engine. Detects animation ticks, counts them
//   against a level-dependent interval, picks a lane pattern for each spawn
//   event and drives four note_lane instances.
//   Ports:
//     clk, rst    - clock, async active-high reset
//     noteAction  - per-lane hit / clear request
//     level_num   - 0 idle, 1..3 difficulty
//     animate     - slow signal, each rising edge is one animation tick
//     locations   - lane i position in bits [4i+3:4i], 0 = empty
//     note_spawn  - one-clk pulse per lane when that lane loads SPAWN_POS

module note_spawner
  import note_pkg::*;
#(
  parameter int P_POS_W     = POS_W,
  parameter int P_SPAWN_POS = SPAWN_POS,
  parameter int P_INT_L1    = INT_L1,
  parameter int P_INT_L2    = INT_L2,
  parameter int P_INT_L3    = INT_L3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_LANES-1:0]           noteAction,
  input  logic [1:0]                     level_num,
  input  logic                           animate,
  output logic [NUM_LANES*P_POS_W-1:0]   locations,
  output logic [NUM_LANES-1:0]           note_spawn
);

  logic                 animate_q;
  logic [1:0]           level_q;
  logic [2:0]           tick_cnt;
  logic [2:0]           step_cnt;
  logic                 tick;
  logic                 level_change;
  logic [3:0]           interval;
  logic                 spawn_event;
  logic [NUM_LANES-1:0] spawn_mask;

  assign tick         = animate & ~animate_q;
  assign level_change = (level_num != level_q);
  assign interval     = interval_sel(level_num, P_INT_L1, P_INT_L2, P_INT_L3);

  // A level change restarts the schedule, so it suppresses the spawn event
  // on that clk even if a tick lands on it.
  assign spawn_event = tick && !level_change && (level_num != 2'd0) &&
                       ({1'b0, tick_cnt} == (interval - 4'd1));

  assign spawn_mask = spawn_event ? pattern(level_num, step_cnt) : '0;

  // Edge history for tick detection and the level seen last clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      animate_q <= 1'b0;
      level_q   <= 2'd0;
    end else begin
      animate_q <= animate;
      level_q   <= level_num;
    end
  end

  // Tick counter counts up to interval-1 then wraps on the spawn event,
  // advancing the pattern step. Idle level holds the counter at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= 3'd0;
      step_cnt <= 3'd0;
    end else if (level_change) begin
      tick_cnt <= 3'd0;
      step_cnt <= 3'd0;
    end else if (level_num == 2'd0) begin
      tick_cnt <= 3'd0;
    end else if (spawn_event) begin
      tick_cnt <= 3'd0;
      step_cnt <= step_cnt + 3'd1;
    end else if (tick) begin
      tick_cnt <= tick_cnt + 3'd1;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    note_lane #(
      .LANE_POS_W     (P_POS_W),
      .LANE_SPAWN_POS (P_SPAWN_POS)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .spawn_req (spawn_mask[i]),
      .hit       (noteAction[i]),
      .tick      (tick),
      .pos       (locations[P_POS_W*i +: P_POS_W]),
      .spawned   (note_spawn[i])
    );
  end

endmodule

// File: tb/tb_note_spawner.sv
// tb_note_spawner
//   Self-checking bench for note_spawner: directed scenarios plus a random
//   phase, every clk compared against a schedule-level reference model.

module tb_note_spawner;

  logic        clk;
  logic        rst;
  logic [3:0]  noteAction;
  logic [1:0]  level_num;
  logic        animate;
  logic [15:0] locations;
  logic [3:0]  note_spawn;

  int checks;
  int errors;

  // Reference model state: ticks counted since the level was (re)entered.
  int         mTicks;
  int         mLevel;
  bit         mAnimPrev;
  int         mPos [4];
  logic [3:0] mSpawn;
  logic [3:0] capturedSpawn;

  note_spawner dut (
    .clk        (clk),
    .rst        (rst),
    .noteAction (noteAction),
    .level_num  (level_num),
    .animate    (animate),
    .locations  (locations),
    .note_spawn (note_spawn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic int intervalOf(input int lvl);
    case (lvl)
      1: return 8;
      2: return 4;
      3: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] patternOf(input int lvl, input int step);
    if (lvl == 1) begin
      case (step % 4)
        0: return 4'b0001;
        1: return 4'b0010;
        2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end else if (lvl == 2) begin
      case (step)
        0: return 4'b0001;
        1: return 4'b0100;
        2: return 4'b0010;
        3: return 4'b1000;
        4: return 4'b0101;
        5: return 4'b1010;
        6: return 4'b0011;
        default: return 4'b1100;
      endcase
    end else begin
      case (step)
        0: return 4'b0011;
        1: return 4'b0110;
        2: return 4'b1100;
        3: return 4'b1001;
        4: return 4'b0101;
        5: return 4'b1010;
        6: return 4'b1111;
        default: return 4'b0000;
      endcase
    end
  endfunction

  function automatic logic [15:0] modelLocations();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'(mPos[i]);
    return v;
  endfunction

  task automatic modelReset();
    mTicks    = 0;
    mLevel    = 0;
    mAnimPrev = 1'b0;
    mSpawn    = '0;
    for (int i = 0; i < 4; i++) mPos[i] = 0;
  endtask

  // Spawn events fall on every interval-th tick since the level was entered;
  // the n-th such event uses step (n-1) mod 8.
  task automatic modelStep(input bit a, input int lvl, input logic [3:0] act);
    bit         tick;
    logic [3:0] mask;
    int         iv;
    tick      = a && !mAnimPrev;
    mAnimPrev = a;
    mask      = '0;
    if (lvl != mLevel) begin
      mLevel = lvl;
      mTicks = 0;
    end else if (lvl != 0 && tick) begin
      mTicks++;
      iv = intervalOf(lvl);
      if (mTicks % iv == 0) mask = patternOf(lvl, ((mTicks / iv) - 1) % 8);
    end
    mSpawn = '0;
    for (int i = 0; i < 4; i++) begin
      if (mask[i] && (mPos[i] == 0 || act[i])) begin
        mPos[i]   = 15;
        mSpawn[i] = 1'b1;
      end else if (act[i]) begin
        mPos[i] = 0;
      end else if (tick && mPos[i] != 0) begin
        mPos[i] = mPos[i] - 1;
      end
    end
  endtask

  // Called at a negedge: drive inputs, advance the model, compare after the edge.
  task automatic applyStimulus(input bit a, input logic [1:0] lvl,
                               input logic [3:0] act);
    animate    = a;
    level_num  = lvl;
    noteAction = act;
    modelStep(a, int'(lvl), act);
    @(posedge clk);
    #1;
    checkOutput("locations", 32'(locations), 32'(modelLocations()));
    checkOutput("note_spawn", 32'(note_spawn), 32'(mSpawn));
    @(negedge clk);
  endtask

  // One full animate period; the tick lands on the first clk.
  task automatic doTick(input logic [1:0] lvl, input logic [3:0] act);
    applyStimulus(1'b1, lvl, act);
    capturedSpawn = note_spawn;
    applyStimulus(1'b1, lvl, 4'b0000);
    applyStimulus(1'b0, lvl, 4'b0000);
    applyStimulus(1'b0, lvl, 4'b0000);
  endtask

  task automatic doReset();
    rst = 1'b1;
    animate = 1'b0;
    noteAction = '0;
    #1;
    checkOutput("async_rst_loc", 32'(locations), 32'h0);
    checkOutput("async_rst_spawn", 32'(note_spawn), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    int period;
    int lvlR;
    logic [3:0] actR;
    bit anim;
    logic [3:0] spawnSeen;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    animate = 1'b0;
    level_num = 2'd1;
    noteAction = '0;
    modelReset();

    // Reset held with animate toggling.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      animate = ~animate;
      @(posedge clk);
      #1;
      checkOutput("reset_loc", 32'(locations), 32'h0);
      checkOutput("reset_spawn", 32'(note_spawn), 32'h0);
    end
    @(negedge clk);
    animate = 1'b0;
    rst = 1'b0;
    modelReset();

    // Level 1 schedule.
    applyStimulus(1'b0, 2'd1, 4'b0000);
    applyStimulus(1'b0, 2'd1, 4'b0000);
    for (int t = 1; t <= 7; t++) doTick(2'd1, 4'b0000);
    checkOutput("l1_before_8th", 32'(locations), 32'h0);
    doTick(2'd1, 4'b0000);
    checkOutput("l1_spawn8", 32'(capturedSpawn), 32'h1);
    checkOutput("l1_loc8", 32'(locations), 32'h000F);
    checkOutput("l1_pulse_gone", 32'(note_spawn), 32'h0);
    for (int t = 9; t <= 15; t++) doTick(2'd1, 4'b0000);
    checkOutput("l1_loc15", 32'(locations), 32'h0008);
    doTick(2'd1, 4'b0000);
    checkOutput("l1_spawn16", 32'(capturedSpawn), 32'h2);
    checkOutput("l1_loc16", 32'(locations), 32'h00F7);

    // Hit lane 1 while it sits at 9; lane 0 is at 1.
    for (int t = 17; t <= 22; t++) doTick(2'd1, 4'b0000);
    checkOutput("pre_hit_loc", 32'(locations), 32'h0091);
    applyStimulus(1'b0, 2'd1, 4'b0010);
    checkOutput("hit_loc", 32'(locations), 32'h0001);
    checkOutput("hit_spawn", 32'(note_spawn), 32'h0);
    doTick(2'd1, 4'b0000);
    checkOutput("miss_loc", 32'(locations), 32'h0000);
    checkOutput("miss_spawn", 32'(capturedSpawn), 32'h0);

    // Level 1 -> 2 restarts the schedule: spawn on the 4th tick, step 0.
    applyStimulus(1'b0, 2'd2, 4'b0000);
    for (int t = 1; t <= 3; t++) doTick(2'd2, 4'b0000);
    checkOutput("l2_spawn3", 32'(capturedSpawn), 32'h0);
    doTick(2'd2, 4'b0000);
    checkOutput("l2_spawn4", 32'(capturedSpawn), 32'h1);
    checkOutput("l2_loc4", 32'(locations), 32'h000F);

    // Idle level: no spawns, the note still falls out.
    applyStimulus(1'b0, 2'd0, 4'b0000);
    spawnSeen = '0;
    for (int t = 0; t < 16; t++) begin
      doTick(2'd0, 4'b0000);
      spawnSeen = spawnSeen | capturedSpawn;
    end
    checkOutput("idle_spawns", 32'(spawnSeen), 32'h0);
    checkOutput("idle_loc", 32'(locations), 32'h0);

    // Mid-run async reset with notes present.
    applyStimulus(1'b0, 2'd3, 4'b0000);
    for (int t = 1; t <= 3; t++) doTick(2'd3, 4'b0000);
    doReset();

    // Level 3, lane 0 occupied when 1001 fires, lane 3 cleared beforehand.
    applyStimulus(1'b0, 2'd3, 4'b0000);
    applyStimulus(1'b0, 2'd3, 4'b0000);
    for (int t = 1; t <= 7; t++) doTick(2'd3, 4'b0000);
    applyStimulus(1'b0, 2'd3, 4'b1000);
    doTick(2'd3, 4'b0000);
    checkOutput("occ_spawn", 32'(capturedSpawn), 32'h8);
    checkOutput("occ_lane0", 32'(locations[3:0]), 32'h9);
    checkOutput("occ_lane3", 32'(locations[15:12]), 32'hF);

    // Same, but lane 0 is hit in the spawn clk so it reloads.
    doReset();
    applyStimulus(1'b0, 2'd3, 4'b0000);
    applyStimulus(1'b0, 2'd3, 4'b0000);
    for (int t = 1; t <= 7; t++) doTick(2'd3, 4'b0000);
    applyStimulus(1'b0, 2'd3, 4'b1000);
    doTick(2'd3, 4'b0001);
    checkOutput("hitspawn_spawn", 32'(capturedSpawn), 32'h9);
    checkOutput("hitspawn_lane0", 32'(locations[3:0]), 32'hF);
    checkOutput("hitspawn_lane3", 32'(locations[15:12]), 32'hF);

    // Random phase against the model.
    lvlR = 1;
    anim = 1'b0;
    period = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) lvlR = $urandom_range(0, 3);
      if (period == 0) begin
        anim = ~anim;
        period = $urandom_range(1, 5);
      end
      period--;
      actR = '0;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 24) == 0) actR[i] = 1'b1;
      applyStimulus(anim, 2'(lvlR), actR);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
